// File: rtl/ht_head_table_pkg.sv
// Shared types for the hash-table head stage: command, head RAM word, downstream payload,
// head-pointer write-back record and the clear-sweep state encoding.
package ht_head_table_pkg;

  localparam int HT_BUCKET_WIDTH   = 8;
  localparam int HT_HEAD_PTR_WIDTH = 10;
  localparam int HT_KEY_WIDTH      = 16;

  typedef enum logic [1:0] {
    OP_SEARCH = 2'd0,
    OP_INSERT = 2'd1,
    OP_DELETE = 2'd2,
    OP_INIT   = 2'd3
  } ht_opcode_t;

  typedef struct packed {
    ht_opcode_t              opcode;
    logic [HT_KEY_WIDTH-1:0] key;
  } ht_command_t;

  typedef struct packed {
    logic [HT_HEAD_PTR_WIDTH-1:0] ptr;
    logic                         ptr_val;
  } head_ram_data_t;

  typedef struct packed {
    ht_command_t                  cmd;
    logic [HT_BUCKET_WIDTH-1:0]   bucket;
    logic [HT_HEAD_PTR_WIDTH-1:0] head_ptr;
    logic                         head_ptr_val;
  } ht_pdata_t;

  typedef struct packed {
    logic [HT_BUCKET_WIDTH-1:0] bucket;
    head_ram_data_t             data;
  } ht_head_wr_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } init_state_t;

endpackage

// File: rtl/ht_head_table_ram.sv
// Head-pointer RAM: 1 write / 1 registered read port, old data on same-address collision.
// No reset; contents are defined only by the clear sweep or explicit writes.
module ht_head_table_ram #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] q
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) q <= mem[raddr];
  end

endmodule

// File: rtl/ht_head_table.sv
// Reads the bucket head pointer for each command (latency 2, 1/clk) with write-back forwarding;
// ready_o drops when s1 and output are full and ready_i is low, and for the whole clear sweep.
module ht_head_table
  import ht_head_table_pkg::*;
#(
  parameter bit AUTO_INIT      = 1'b1,
  parameter int BUCKET_WIDTH   = HT_BUCKET_WIDTH,
  parameter int HEAD_PTR_WIDTH = HT_HEAD_PTR_WIDTH
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  ht_command_t             cmd_i,
  input  logic [BUCKET_WIDTH-1:0] bucket_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  output ht_pdata_t               pdata_o,
  output logic                    valid_o,
  input  logic                    ready_i,
  input  ht_head_wr_t             head_wr_i,
  input  logic                    head_wr_en_i,
  output logic                    init_busy_o
);

  init_state_t             state, state_nxt;
  logic [BUCKET_WIDTH:0]   cnt, cnt_nxt;

  logic                    in_xfer;
  logic                    s1_adv;
  logic                    wr_en;

  logic                    s1_valid;
  ht_command_t             s1_cmd;
  logic [BUCKET_WIDTH-1:0] s1_bucket;
  logic                    s1_ovr_vld;
  head_ram_data_t          s1_ovr;
  head_ram_data_t          s1_head;

  logic                    ram_we;
  logic [BUCKET_WIDTH-1:0] ram_waddr;
  head_ram_data_t          ram_wdata;
  head_ram_data_t          ram_q;

  assign init_busy_o = (state == ST_CLEAR);
  assign ready_o     = !init_busy_o && (!s1_valid || !valid_o || ready_i);
  assign in_xfer     = valid_i && ready_o;
  assign s1_adv      = s1_valid && !init_busy_o && (!valid_o || ready_i);
  assign wr_en       = head_wr_en_i && !init_busy_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= AUTO_INIT ? ST_CLEAR : ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // The extra counter bit flags the wrap out of the last bucket.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (in_xfer && cmd_i.opcode == OP_INIT) state_nxt = ST_CLEAR;
      end
      ST_CLEAR: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt_nxt[BUCKET_WIDTH]) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    ram_we    = init_busy_o || head_wr_en_i;
    ram_waddr = init_busy_o ? cnt[BUCKET_WIDTH-1:0] : head_wr_i.bucket;
    ram_wdata = init_busy_o ? '0 : head_wr_i.data;
  end

  ht_head_table_ram #(
    .ADDR_WIDTH (BUCKET_WIDTH),
    .DATA_WIDTH (HEAD_PTR_WIDTH + 1)
  ) u_ram (
    .clk   (clk_i),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (in_xfer),
    .raddr (bucket_i),
    .q     (ram_q)
  );

  // A write landing in the same cycle s1 moves on must reach the output too.
  always_comb begin
    if (wr_en && head_wr_i.bucket == s1_bucket) s1_head = head_wr_i.data;
    else if (s1_ovr_vld)                        s1_head = s1_ovr;
    else                                        s1_head = ram_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid   <= 1'b0;
      s1_ovr_vld <= 1'b0;
    end else if (in_xfer) begin
      s1_valid <= 1'b1;
      if (cmd_i.opcode == OP_INIT) begin
        s1_ovr_vld <= 1'b1;
      end else begin
        s1_ovr_vld <= wr_en && head_wr_i.bucket == bucket_i;
      end
    end else begin
      if (s1_adv) s1_valid <= 1'b0;
      if (wr_en && head_wr_i.bucket == s1_bucket) s1_ovr_vld <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (in_xfer) begin
      s1_cmd    <= cmd_i;
      s1_bucket <= bucket_i;
      // OP_INIT leaves with an empty head once the sweep has finished.
      s1_ovr    <= (cmd_i.opcode == OP_INIT) ? '0 : head_wr_i.data;
    end else if (wr_en && head_wr_i.bucket == s1_bucket) begin
      s1_ovr <= head_wr_i.data;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_o <= 1'b0;
      pdata_o <= '0;
    end else if (s1_adv) begin
      valid_o              <= 1'b1;
      pdata_o.cmd          <= s1_cmd;
      pdata_o.bucket       <= s1_bucket;
      pdata_o.head_ptr     <= s1_head.ptr;
      pdata_o.head_ptr_val <= s1_head.ptr_val;
    end else if (valid_o && ready_i) begin
      valid_o <= 1'b0;
    end else if (valid_o && wr_en && head_wr_i.bucket == pdata_o.bucket) begin
      pdata_o.head_ptr     <= head_wr_i.data.ptr;
      pdata_o.head_ptr_val <= head_wr_i.data.ptr_val;
    end
  end

  a_no_wr_during_clear: assert property (@(posedge clk_i) disable iff (rst_i)
    !(init_busy_o && head_wr_en_i));

endmodule
